t_ff_toggle_arbiter: RTL and testbench

//   Shares one T flip-flop between NREQ requesters. Each request is a toggle

---
 rtl/t_ff_toggle_arbiter.sv | 113 +++++++++++
 tb/tb_t_ff_toggle_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/t_ff_toggle_arbiter.sv
// Round-robin arbiter sharing one T flip-flop among NREQ toggle requesters,
// with a programmable idle gap after every toggle and Q kept internally.
module t_ff_toggle_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned GAP_W = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [NREQ-1:0]  req,
    input  logic [GAP_W-1:0] gap,
    output logic             T,
    output logic             Q,
    output logic [NREQ-1:0]  grant,
    output logic [NREQ-1:0]  ack,
    output logic [NREQ-1:0]  pending,
    output logic             busy
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_inc;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   winner_nxt;
    logic [PTR_W-1:0]   rr_sel;
    logic               rr_found;
    logic [GAP_W-1:0]   gap_cnt;

    // Round-robin search of pending starting at ptr, wrapping modulo NREQ
    always_comb begin
        int unsigned idx;
        rr_found = 1'b0;
        rr_sel   = '0;
        idx      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr) + i) % NREQ;
            if (!rr_found && pending[PTR_W'(idx)]) begin
                rr_found = 1'b1;
                rr_sel   = PTR_W'(idx);
            end
        end
    end

    assign ptr_inc = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + PTR_W'(1);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        winner_nxt = winner;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_nxt  = GRANT;
                    winner_nxt = rr_sel;
                end
            end
            GRANT: begin
                state_nxt = (gap != '0) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt == GAP_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath; T/grant/busy are registered from the next-state decode
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pending <= '0;
            ptr     <= '0;
            winner  <= '0;
            gap_cnt <= '0;
            Q       <= 1'b0;
            T       <= 1'b0;
            grant   <= '0;
            busy    <= 1'b0;
        end else begin
            pending <= (pending & ~grant) | req;
            winner  <= winner_nxt;
            T       <= (state_nxt == GRANT);
            grant   <= (state_nxt == GRANT) ? (NREQ'(1) << winner_nxt) : '0;
            busy    <= (state_nxt != IDLE);
            if (state == GRANT) begin
                Q       <= ~Q;
                ptr     <= ptr_inc;
                gap_cnt <= gap;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    assign ack = grant;

endmodule

// File: tb/tb_t_ff_toggle_arbiter.sv
// Directed bench for t_ff_toggle_arbiter: reset, single/multi requests,
// gap timing, fairness and reset during GAP.
module tb_t_ff_toggle_arbiter;

    logic       CLK;
    logic       Reset;
    logic [3:0] req;
    logic [3:0] gap;
    logic       T;
    logic       Q;
    logic [3:0] grant;
    logic [3:0] ack;
    logic [3:0] pending;
    logic       busy;

    int checks;
    int errors;

    t_ff_toggle_arbiter #(.NREQ(4), .GAP_W(4)) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .req     (req),
        .gap     (gap),
        .T       (T),
        .Q       (Q),
        .grant   (grant),
        .ack     (ack),
        .pending (pending),
        .busy    (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        req   = '0;
        gap   = '0;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        Reset = 1'b1;
        req   = 4'b1111;
        gap   = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            obs = {T, grant, ack, busy, Q, pending};
            checks++;
            if (obs !== 15'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: got %b expected %b", c, obs, 15'b0);
            end
        end
        Reset = 1'b0;
        step();
        checks++;
        if (pending !== 4'b1111 || grant !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release_pend: pending=%b grant=%b expected 1111/0000", pending, grant);
        end
        step();
        checks++;
        if (grant !== 4'b0001 || ack !== 4'b0001 || T !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: grant=%b ack=%b T=%b expected 0001/0001/1", grant, ack, T);
        end
        req = '0;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        step();
        req = '0;
        checks++;
        if (pending !== 4'b0100 || T !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_latch: pending=%b T=%b busy=%b expected 0100/0/0", pending, T, busy);
        end
        step();
        checks++;
        if ({T, grant, ack, busy, Q} !== {1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_grant: T=%b grant=%b ack=%b busy=%b Q=%b expected 1/0100/0100/1/0",
                     T, grant, ack, busy, Q);
        end
        step();
        checks++;
        if ({T, grant, busy, Q, pending} !== {1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL single_after: T=%b grant=%b busy=%b Q=%b pending=%b expected 0/0000/0/1/0000",
                     T, grant, busy, Q, pending);
        end
    endtask

    task automatic test_all_four();
        logic [3:0] exp_g;
        do_reset();
        req = 4'b1111;
        step();
        req = '0;
        for (int k = 2; k <= 9; k++) begin
            step();
            case (k)
                2: exp_g = 4'b0001;
                4: exp_g = 4'b0010;
                6: exp_g = 4'b0100;
                8: exp_g = 4'b1000;
                default: exp_g = 4'b0000;
            endcase
            checks++;
            if (grant !== exp_g || T !== (exp_g != 4'b0000)) begin
                errors++;
                $display("FAIL all4_grant k%0d: grant=%b T=%b expected %b/%b", k, grant, T, exp_g,
                         exp_g != 4'b0000);
            end
        end
        checks++;
        if (Q !== 1'b0 || pending !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL all4_end: Q=%b pending=%b busy=%b expected 0/0000/0", Q, pending, busy);
        end
    endtask

    task automatic test_gap();
        logic exp_t;
        logic exp_q;
        do_reset();
        gap = 4'd3;
        req = 4'b0001;
        for (int k = 1; k <= 22; k++) begin
            step();
            exp_t = (k >= 2) && (((k - 2) % 5) == 0);
            exp_q = (k >= 3) ? ((((k - 3) / 5) % 2) == 0) : 1'b0;
            checks++;
            if (T !== exp_t || grant !== (exp_t ? 4'b0001 : 4'b0000) || Q !== exp_q) begin
                errors++;
                $display("FAIL gap3 k%0d: T=%b grant=%b Q=%b expected %b/%b/%b", k, T, grant, Q,
                         exp_t, exp_t ? 4'b0001 : 4'b0000, exp_q);
            end
        end
        req = '0;
        gap = '0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g;
        do_reset();
        req = 4'b0011;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k >= 2 && (k % 2) == 0) begin
                exp_g = (((k / 2) % 2) == 1) ? 4'b0001 : 4'b0010;
            end else begin
                exp_g = 4'b0000;
            end
            checks++;
            if (grant !== exp_g || ack !== exp_g) begin
                errors++;
                $display("FAIL fair k%0d: grant=%b ack=%b expected %b", k, grant, ack, exp_g);
            end
        end
        req = '0;
    endtask

    task automatic test_reset_in_gap();
        do_reset();
        gap = 4'd5;
        req = 4'b0001;
        step();
        req = '0;
        step();
        step();
        step();
        checks++;
        if (busy !== 1'b1 || T !== 1'b0 || Q !== 1'b1) begin
            errors++;
            $display("FAIL gap_pre_reset: busy=%b T=%b Q=%b expected 1/0/1", busy, T, Q);
        end
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if ({T, grant, ack, busy, Q, pending} !== 15'b0) begin
            errors++;
            $display("FAIL gap_async_reset: got %b expected %b", {T, grant, ack, busy, Q, pending}, 15'b0);
        end
        step();
        Reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if ({T, grant, busy, Q} !== 7'b0) begin
                errors++;
                $display("FAIL gap_after_reset k%0d: T=%b grant=%b busy=%b Q=%b expected all 0",
                         k, T, grant, busy, Q);
            end
        end
        gap = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        req    = '0;
        gap    = '0;
        test_reset();
        test_single();
        test_all_four();
        test_gap();
        test_back_to_back();
        test_reset_in_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
